// File: rtl/rf_wport_ctrl_pkg.sv
// Shared types and sizes for the register-file write-port controller.
package rf_wport_ctrl_pkg;

    localparam int unsigned REG_W  = 5;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned NREG   = 32;

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StForce
    } arb_state_e;

endpackage

// File: rtl/rf_wport_ctrl_if.sv
// Bundle of WB, MDU, issue, ID-hazard and RF-write signals around the write-port controller.
interface rf_wport_ctrl_if;
    import rf_wport_ctrl_pkg::*;

    logic              wb_we;
    logic [REG_W-1:0]  wb_wR;
    logic [DATA_W-1:0] wb_wD;
    logic              wb_hold;
    logic              mdu_valid;
    logic [REG_W-1:0]  mdu_wR;
    logic [DATA_W-1:0] mdu_wD;
    logic              mdu_ready;
    logic              issue_valid;
    logic [REG_W-1:0]  issue_rd;
    logic              issue_ready;
    logic [REG_W-1:0]  id_rs1;
    logic [REG_W-1:0]  id_rs2;
    logic [REG_W-1:0]  id_rd;
    logic              id_we;
    logic              id_stall;
    logic              rf_we;
    logic [REG_W-1:0]  rf_wR;
    logic [DATA_W-1:0] rf_wD;

    modport slave (
        input  wb_we, wb_wR, wb_wD, mdu_valid, mdu_wR, mdu_wD,
        input  issue_valid, issue_rd, id_rs1, id_rs2, id_rd, id_we,
        output wb_hold, mdu_ready, issue_ready, id_stall, rf_we, rf_wR, rf_wD
    );

    modport master (
        output wb_we, wb_wR, wb_wD, mdu_valid, mdu_wR, mdu_wD,
        output issue_valid, issue_rd, id_rs1, id_rs2, id_rd, id_we,
        input  wb_hold, mdu_ready, issue_ready, id_stall, rf_we, rf_wR, rf_wD
    );

endinterface

// File: rtl/rf_wport_ctrl_scoreboard.sv
// Pending-MDU-destination scoreboard: busy bits, outstanding count, issue gate and ID stall.
module rf_wport_ctrl_scoreboard
    import rf_wport_ctrl_pkg::*;
#(
    parameter int unsigned MAX_OUT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_valid,
    input  logic [REG_W-1:0] issue_rd,
    input  logic             mdu_hs,
    input  logic [REG_W-1:0] mdu_wR,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_we,
    output logic             issue_ready,
    output logic             id_stall
);

    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam logic [OUT_W-1:0] MaxOutV = OUT_W'(MAX_OUT);

    logic [NREG-1:0]  busy_q, busy_d;
    logic [OUT_W-1:0] out_cnt_q, out_cnt_d;
    logic             issue_hs;

    always_comb begin
        issue_ready = !rst && (out_cnt_q < MaxOutV) && (issue_rd == '0 || !busy_q[issue_rd]);
        issue_hs    = issue_valid && issue_ready;
        // Registered busy only: a result written this cycle unstalls ID next cycle.
        id_stall    = !rst && ((id_rs1 != '0 && busy_q[id_rs1]) ||
                               (id_rs2 != '0 && busy_q[id_rs2]) ||
                               (id_we && id_rd != '0 && busy_q[id_rd]));

        busy_d = busy_q;
        if (mdu_hs) busy_d[mdu_wR] = 1'b0;
        if (issue_hs && issue_rd != '0) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;

        out_cnt_d = out_cnt_q;
        if (issue_hs && !mdu_hs) begin
            out_cnt_d = out_cnt_q + OUT_W'(1);
        end else if (!issue_hs && mdu_hs && out_cnt_q != '0) begin
            out_cnt_d = out_cnt_q - OUT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            out_cnt_q <= '0;
        end else begin
            busy_q    <= busy_d;
            out_cnt_q <= out_cnt_d;
        end
    end

endmodule

// File: rtl/rf_wport_ctrl.sv
// Register-file write-port arbiter: WB has priority, MDU gets a forced slot after MAX_WAIT losses.
module rf_wport_ctrl
    import rf_wport_ctrl_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4,
    parameter int unsigned MAX_OUT  = 4
) (
    input logic           clk,
    input logic           rst,
    rf_wport_ctrl_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] CntLast = CNT_W'(MAX_WAIT - 1);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wb_req;
    logic             grant_wb;
    logic             grant_mdu;
    logic             mdu_hs;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        grant_wb      = 1'b0;
        grant_mdu     = 1'b0;
        bus.mdu_ready = 1'b0;
        bus.wb_hold   = 1'b0;
        wb_req        = bus.wb_we && bus.wb_wR != '0;

        if (!rst) begin
            case (state_q)
                StForce: begin
                    // WB is not written here; the pipeline re-presents it next cycle.
                    bus.mdu_ready = 1'b1;
                    grant_mdu     = bus.mdu_valid;
                    bus.wb_hold   = wb_req;
                    state_d       = StIdle;
                    cnt_d         = '0;
                end
                default: begin
                    if (wb_req) begin
                        grant_wb = 1'b1;
                        if (!bus.mdu_valid) begin
                            state_d = StIdle;
                            cnt_d   = '0;
                        end else begin
                            state_d = (cnt_q == CntLast) ? StForce : StWait;
                            cnt_d   = cnt_q + CNT_W'(1);
                        end
                    end else begin
                        bus.mdu_ready = bus.mdu_valid;
                        grant_mdu     = bus.mdu_valid;
                        state_d       = StIdle;
                        cnt_d         = '0;
                    end
                end
            endcase
        end

        mdu_hs = bus.mdu_valid && bus.mdu_ready;

        bus.rf_we = 1'b0;
        bus.rf_wR = '0;
        bus.rf_wD = '0;
        if (grant_mdu && bus.mdu_wR != '0) begin
            bus.rf_we = 1'b1;
            bus.rf_wR = bus.mdu_wR;
            bus.rf_wD = bus.mdu_wD;
        end else if (grant_wb) begin
            bus.rf_we = 1'b1;
            bus.rf_wR = bus.wb_wR;
            bus.rf_wD = bus.wb_wD;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    rf_wport_ctrl_scoreboard #(
        .MAX_OUT(MAX_OUT)
    ) u_scoreboard (
        .clk        (clk),
        .rst        (rst),
        .issue_valid(bus.issue_valid),
        .issue_rd   (bus.issue_rd),
        .mdu_hs     (mdu_hs),
        .mdu_wR     (bus.mdu_wR),
        .id_rs1     (bus.id_rs1),
        .id_rs2     (bus.id_rs2),
        .id_rd      (bus.id_rd),
        .id_we      (bus.id_we),
        .issue_ready(bus.issue_ready),
        .id_stall   (bus.id_stall)
    );

endmodule
